// File: rtl/gfx_line_if.sv
// gfx_line_if -- command and pixel handshakes of the gfx_line rasteriser.
//
// Handshake rule (both channels): a transfer happens on every rising clk
// edge where valid and ready are both high; the source holds its payload
// stable while valid is high and ready is low.
//
// Signals:
//   cmd_x0/cmd_y0/cmd_x1/cmd_y1/cmd_color, cmd_valid -> rasteriser, cmd_ready <-
//   gfx_x/gfx_y/gfx_color, gfx_valid <- rasteriser, gfx_ready ->
//   busy, done, state_dbg  status outputs of the rasteriser
// Modports: master = command source / pixel sink, slave = rasteriser.
interface gfx_line_if #(
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int PIXEL_BITS = 12
);
    logic [X_BITS-1:0]     cmd_x0;
    logic [X_BITS-1:0]     cmd_x1;
    logic [Y_BITS-1:0]     cmd_y0;
    logic [Y_BITS-1:0]     cmd_y1;
    logic [PIXEL_BITS-1:0] cmd_color;
    logic                  cmd_valid;
    logic                  cmd_ready;

    logic [X_BITS-1:0]     gfx_x;
    logic [Y_BITS-1:0]     gfx_y;
    logic [PIXEL_BITS-1:0] gfx_color;
    logic                  gfx_valid;
    logic                  gfx_ready;

    logic                  busy;
    logic                  done;
    logic [1:0]            state_dbg;

    modport master (
        output cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_valid, gfx_ready,
        input  cmd_ready, gfx_x, gfx_y, gfx_color, gfx_valid, busy, done, state_dbg
    );

    modport slave (
        input  cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_valid, gfx_ready,
        output cmd_ready, gfx_x, gfx_y, gfx_color, gfx_valid, busy, done, state_dbg
    );
endinterface

// File: rtl/gfx_line.sv
// gfx_line -- Bresenham line rasteriser.
//
// Accepts one line command (two endpoints + color) in IDLE, spends one INIT
// cycle computing the error terms, then emits one pixel per accepted gfx
// transfer in DRAW until the end point has been transferred, then pulses done.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    gfx_line_if.slave (command in, pixel out, busy/done/state_dbg)
//
// Optional feature: define GFX_LINE_CLIP_EN to skip (in one cycle, without
// a gfx transfer) any pixel lying outside FB_WIDTH x FB_HEIGHT.
module gfx_line #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int PIXEL_BITS = 12
) (
    input  logic     clk,
    input  logic     reset,
    gfx_line_if.slave bus
);
    localparam int X_BITS  = $clog2(FB_WIDTH);
    localparam int Y_BITS  = $clog2(FB_HEIGHT);
    localparam int XY_BITS = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
    // Two extra bits: one for sign, one so dx-dy cannot overflow.
    localparam int W = XY_BITS + 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] INIT = 2'd1;
    localparam logic [1:0] DRAW = 2'd2;

    logic [1:0]            state;
    logic [X_BITS-1:0]     x0_q, x1_q, cur_x;
    logic [Y_BITS-1:0]     y0_q, y1_q, cur_y;
    logic [PIXEL_BITS-1:0] color_q;
    logic                  done_q;
    logic                  sx_neg, sy_neg;

    logic signed [W-1:0]   dx, dy, err;
    logic signed [W-1:0]   diff_x, diff_y, abs_x, abs_y, err_nxt;
    logic signed [W:0]     e2;
    logic                  step_x, step_y, at_end, visible, advance;

    always_comb begin
        diff_x  = $signed(W'(x1_q)) - $signed(W'(x0_q));
        diff_y  = $signed(W'(y1_q)) - $signed(W'(y0_q));
        abs_x   = (diff_x < 0) ? -diff_x : diff_x;
        abs_y   = (diff_y < 0) ? -diff_y : diff_y;
        e2      = $signed({err, 1'b0});
        // Both decisions use the pre-update err; a diagonal step applies both.
        step_x  = (e2 >= $signed({dy[W-1], dy}));
        step_y  = (e2 <= $signed({dx[W-1], dx}));
        err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
        at_end  = (cur_x == x1_q) && (cur_y == y1_q);
`ifdef GFX_LINE_CLIP_EN
        visible = ({1'b0, cur_x} < (X_BITS+1)'(FB_WIDTH)) &&
                  ({1'b0, cur_y} < (Y_BITS+1)'(FB_HEIGHT));
`else
        visible = 1'b1;
`endif
        // An invisible pixel steps without waiting for the pixel sink.
        advance = (state == DRAW) && (!visible || bus.gfx_ready);
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.gfx_valid = (state == DRAW) && visible;
    assign bus.gfx_x     = cur_x;
    assign bus.gfx_y     = cur_y;
    assign bus.gfx_color = color_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            cur_x   <= '0;
            cur_y   <= '0;
            color_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x0_q    <= bus.cmd_x0;
                        y0_q    <= bus.cmd_y0;
                        x1_q    <= bus.cmd_x1;
                        y1_q    <= bus.cmd_y1;
                        color_q <= bus.cmd_color;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    dx     <= abs_x;
                    dy     <= -abs_y;
                    err    <= abs_x - abs_y;
                    sx_neg <= !(x0_q < x1_q);
                    sy_neg <= !(y0_q < y1_q);
                    cur_x  <= x0_q;
                    cur_y  <= y0_q;
                    state  <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (at_end) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            if (step_x) cur_x <= sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
                            if (step_y) cur_y <= sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
                            err <= err_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gfx_line.sv
// tb_gfx_line -- self-checking bench for gfx_line.
// Directed lines (horizontal, steep, reverse, single point, stalled, all
// octants, framebuffer edge, mid-line reset) followed by random lines with
// random pixel back-pressure and command noise while busy.
module tb_gfx_line;
    localparam int FB_WIDTH   = 640;
    localparam int FB_HEIGHT  = 480;
    localparam int PIXEL_BITS = 12;
    localparam int X_BITS     = $clog2(FB_WIDTH);
    localparam int Y_BITS     = $clog2(FB_HEIGHT);
    localparam int PW         = X_BITS + Y_BITS + PIXEL_BITS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gfx_line_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .PIXEL_BITS(PIXEL_BITS)) bus ();

    gfx_line #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .PIXEL_BITS(PIXEL_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pk(input int x, input int y, input logic [PIXEL_BITS-1:0] c);
        logic [X_BITS-1:0] xb;
        logic [Y_BITS-1:0] yb;
        xb = X_BITS'(x);
        yb = Y_BITS'(y);
        return {xb, yb, c};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit on_screen(input int x, input int y);
`ifdef GFX_LINE_CLIP_EN
        return (x < FB_WIDTH) && (y < FB_HEIGHT);
`else
        return (x >= 0) && (y >= 0);
`endif
    endfunction

    // Reference line: integer Bresenham walk from (x0,y0) to (x1,y1).
    task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                              input logic [PIXEL_BITS-1:0] c);
        int dx, dy, sx, sy, err, e2, x, y;
        dx = iabs(x1 - x0);
        dy = -iabs(y1 - y0);
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        for (int n = 0; n < 5000; n++) begin
            if (on_screen(x, y)) exp_q.push_back(pk(x, y, c));
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input logic [PIXEL_BITS-1:0] c);
        bus.cmd_x0    = X_BITS'(x0);
        bus.cmd_y0    = Y_BITS'(y0);
        bus.cmd_x1    = X_BITS'(x1);
        bus.cmd_y1    = Y_BITS'(y1);
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("init_no_valid", bus.gfx_valid, 0);
        chk("init_busy", bus.busy, 1);
        chk("init_cmd_ready", bus.cmd_ready, 0);
    endtask

    // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random ready
    task automatic run_line(input int mode, input bit noise, input bit check_lat,
                            input bit check_tp, input int exp_n);
        int cyc, got, first;
        bit stalled, done_seen;
        logic [PW-1:0] prev, cur, e;
        cyc = 1;
        got = 0;
        first = -1;
        stalled = 0;
        done_seen = 0;
        prev = '0;
        @(negedge clk);
        while (!done_seen && cyc < 4000) begin
            case (mode)
                0:       bus.gfx_ready = 1'b1;
                1:       bus.gfx_ready = ((cyc - 1) % 3 == 0);
                default: bus.gfx_ready = 1'($urandom_range(1));
            endcase
            if (noise && bus.busy) begin
                bus.cmd_valid = 1'($urandom_range(1));
                bus.cmd_x0 = X_BITS'($urandom_range(FB_WIDTH - 1));
                bus.cmd_x1 = X_BITS'($urandom_range(FB_WIDTH - 1));
                bus.cmd_y0 = Y_BITS'($urandom_range(FB_HEIGHT - 1));
                bus.cmd_y1 = Y_BITS'($urandom_range(FB_HEIGHT - 1));
                bus.cmd_color = PIXEL_BITS'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            cur = {bus.gfx_x, bus.gfx_y, bus.gfx_color};
            if (bus.done) begin
                done_seen = 1;
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_cmd_ready", bus.cmd_ready, 1);
                chk("done_busy", bus.busy, 0);
                chk("done_valid_low", bus.gfx_valid, 0);
            end else begin
                if (stalled) begin
                    chk("stall_valid_hold", bus.gfx_valid, 1);
                    chk("stall_pixel_hold", cur, prev);
                end
                if (bus.gfx_valid) begin
                    if (first < 0) first = cyc;
                    if (bus.gfx_ready) begin
                        got++;
                        if (exp_q.size() == 0) begin
                            chk("extra_pixel", cur, '1);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pixel", cur, e);
                        end
                    end
                    stalled = !bus.gfx_ready;
                    prev = cur;
                end else begin
                    stalled = 0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.cmd_valid = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("pixel_count", got, exp_n);
        if (check_lat) chk("first_valid_latency", first, 1);
        if (check_tp) chk("throughput_cycles", cyc, got + 1);
        exp_q.delete();
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
    endtask

    // ---------------- directed + random sequence ----------------
    int oct_x1[8] = '{110, 103,  97,  90,  90,  97, 103, 110};
    int oct_y1[8] = '{103, 110, 110, 103,  97,  90,  90,  97};

    initial begin
        int x0, y0, x1, y1, n;
        bus.cmd_valid = 1'b0;
        bus.gfx_ready = 1'b0;
        bus.cmd_x0 = '0;
        bus.cmd_x1 = '0;
        bus.cmd_y0 = '0;
        bus.cmd_y1 = '0;
        bus.cmd_color = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gfx_valid", bus.gfx_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gfx_x", bus.gfx_x, 0);
        chk("rst_gfx_y", bus.gfx_y, 0);
        chk("rst_gfx_color", bus.gfx_color, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);

        // horizontal line
        for (int i = 0; i < 4; i++) exp_q.push_back(pk(i, 0, 12'hF00));
        send_cmd(0, 0, 3, 0, 12'hF00);
        run_line(0, 0, 1, 1, 4);

        // steep line
        exp_q.push_back(pk(0, 0, 12'h0A5));
        exp_q.push_back(pk(0, 1, 12'h0A5));
        exp_q.push_back(pk(1, 2, 12'h0A5));
        exp_q.push_back(pk(1, 3, 12'h0A5));
        send_cmd(0, 0, 1, 3, 12'h0A5);
        run_line(0, 0, 1, 1, 4);

        // reverse steep line
        exp_q.push_back(pk(1, 3, 12'h5A0));
        exp_q.push_back(pk(1, 2, 12'h5A0));
        exp_q.push_back(pk(0, 1, 12'h5A0));
        exp_q.push_back(pk(0, 0, 12'h5A0));
        send_cmd(1, 3, 0, 0, 12'h5A0);
        run_line(0, 0, 1, 1, 4);

        // single point
        exp_q.push_back(pk(5, 5, 12'h123));
        send_cmd(5, 5, 5, 5, 12'h123);
        run_line(0, 0, 1, 1, 1);

        // stalled line with ready 1,0,0,...
        model_line(10, 10, 14, 12, 12'h777);
        send_cmd(10, 10, 14, 12, 12'h777);
        run_line(1, 0, 1, 0, 5);

        // all eight octants from (100,100)
        for (int i = 0; i < 8; i++) begin
            model_line(100, 100, oct_x1[i], oct_y1[i], PIXEL_BITS'(i + 1));
            n = ((iabs(oct_x1[i] - 100) > iabs(oct_y1[i] - 100)) ?
                 iabs(oct_x1[i] - 100) : iabs(oct_y1[i] - 100)) + 1;
            send_cmd(100, 100, oct_x1[i], oct_y1[i], PIXEL_BITS'(i + 1));
            run_line(i % 3, 1, 1, (i % 3) == 0, n);
        end

        // line crossing the right framebuffer edge
        model_line(636, 0, 643, 0, 12'hABC);
        send_cmd(636, 0, 643, 0, 12'hABC);
`ifdef GFX_LINE_CLIP_EN
        run_line(0, 0, 1, 0, 4);
`else
        run_line(0, 0, 1, 1, 8);
`endif

        // reset during the third pixel aborts the line
        bus.gfx_ready = 1'b1;
        send_cmd(0, 0, 9, 0, 12'hFFF);
        @(negedge clk);
        chk("abort_pix0_x", bus.gfx_x, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pix2_x", bus.gfx_x, 2);
        chk("abort_pix2_valid", bus.gfx_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_valid_low", bus.gfx_valid, 0);
        chk("abort_no_done", bus.done, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_no_done_after", bus.done, 0);
        chk("abort_busy_low", bus.busy, 0);

        // random lines with random back-pressure and command noise
        for (int i = 0; i < 12; i++) begin
            x0 = $urandom_range(FB_WIDTH - 1);
            x1 = $urandom_range(FB_WIDTH - 1);
            y0 = $urandom_range(FB_HEIGHT - 1);
            y1 = $urandom_range(FB_HEIGHT - 1);
            if (i < 6) begin
                x1 = (x0 + $urandom_range(40)) % FB_WIDTH;
                y1 = (y0 + $urandom_range(40)) % FB_HEIGHT;
            end
            n = ((iabs(x1 - x0) > iabs(y1 - y0)) ? iabs(x1 - x0) : iabs(y1 - y0)) + 1;
            model_line(x0, y0, x1, y1, PIXEL_BITS'($urandom));
            send_cmd(x0, y0, x1, y1, exp_q[0][PIXEL_BITS-1:0]);
            run_line(2, 1, 1, 0, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gfx_line.md
GFX_LINE -- requirements
Module: gfx_line

Interface
REQ-001 Parameter FB_WIDTH, default 640, is the framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, default 480, is the framebuffer height in pixels.
REQ-003 Parameter PIXEL_BITS, default 12, is the color width.
REQ-004 Derived widths SHALL be X_BITS=$clog2(FB_WIDTH) and Y_BITS=$clog2(FB_HEIGHT).
REQ-005 clk  in  1  clock; all logic is on the rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 cmd_x0, cmd_x1  in  X_BITS  line endpoint x coordinates.
REQ-008 cmd_y0, cmd_y1  in  Y_BITS  line endpoint y coordinates.
REQ-009 cmd_color  in  PIXEL_BITS  line color.
REQ-010 cmd_valid  in  1 / cmd_ready  out  1  command handshake.
REQ-011 gfx_x  out  X_BITS / gfx_y  out  Y_BITS / gfx_color  out  PIXEL_BITS  pixel to the framebuffer writer.
REQ-012 gfx_valid  out  1 / gfx_ready  in  1  pixel handshake.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 done  out  1  one-cycle pulse after the final pixel transfers.

Function
REQ-015 A transfer SHALL occur on any cycle where valid&ready are both high, for both the cmd and gfx interfaces.
REQ-016 The FSM SHALL have the states IDLE, INIT and DRAW.
REQ-017 cmd_ready SHALL be high only in IDLE.
REQ-018 A command transfer SHALL latch all cmd_* inputs and go to INIT.
REQ-019 INIT (one cycle) SHALL compute the following, then go to DRAW:
- dx=|x1-x0| and dy=-|y1-y0|;
- sx=+1 if x0<x1, else -1; sy likewise for y;
- err=dx+dy;
- cur=(x0,y0).
REQ-020 err, dx and dy SHALL be signed with width max(X_BITS,Y_BITS)+2, so no overflow occurs at any endpoint combination.
REQ-021 In DRAW, gfx_valid SHALL be high and gfx_x/gfx_y/gfx_color SHALL present cur and the latched color.
REQ-022 While gfx_valid&!gfx_ready, all gfx outputs SHALL hold stable.
REQ-023 On each DRAW transfer:
- if cur==(x1,y1), go to IDLE and pulse done;
- otherwise, with e2=2*err: if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy;
- both updates use the pre-update err, and their sum applies when both are true.
REQ-024 The line SHALL produce exactly max(dx,-dy)+1 pixels; x0==x1&&y0==y1 produces one pixel.
REQ-025 Latency: command accepted at cycle N -> first gfx_valid at N+2.
REQ-026 Throughput SHALL be one pixel per cycle while gfx_ready is held high.
REQ-027 After the last transfer, cmd_ready SHALL be high the next cycle (IDLE).
REQ-028 Endpoints at all 8 octants, including the reverse direction, SHALL be supported.
REQ-029 cmd_valid outside IDLE SHALL be ignored, with no effect on the line in progress.
REQ-030 gfx_ready in IDLE/INIT SHALL be ignored.

Reset
REQ-031 Reset SHALL force: state IDLE, gfx_valid=0, done=0, busy=0, gfx_x=0, gfx_y=0, gfx_color=0.
REQ-032 After reset, cmd_ready SHALL be 1 on the first cycle reset is low.
REQ-033 Reset mid-line SHALL abort the line: gfx_valid=0 on the cycle after reset is sampled, and no done pulse.

Configuration
REQ-034 Macro GFX_LINE_CLIP_EN defined: in DRAW, any cur with x>=FB_WIDTH or y>=FB_HEIGHT SHALL be stepped in one cycle.
- gfx_valid stays low for that cycle and gfx_ready is not required.
- The done/termination rule of REQ-023 still applies.
REQ-035 Macro GFX_LINE_CLIP_EN undefined: every pixel SHALL be emitted unconditionally, with no clip comparators synthesized.

Verification
REQ-036 Horizontal line (0,0)-(3,0), color 0xF00, gfx_ready=1 -> pixels x=0,1,2,3 at y=0 on consecutive cycles, first at N+2; done pulse, then cmd_ready=1.
REQ-037 Steep line (0,0)-(1,3) -> exactly (0,0),(0,1),(1,2),(1,3).
REQ-038 Reverse line (1,3)-(0,0) -> exactly (1,3),(1,2),(0,1),(0,0).
REQ-039 Line (5,5)-(5,5) -> a single pixel (5,5), then done.
REQ-040 Line (10,10)-(14,12), gfx_ready toggled 1,0,0,1,... -> 5 pixels in order, outputs stable while stalled, no drops or duplicates.
REQ-041 Line (636,0)-(643,0) -> with GFX_LINE_CLIP_EN: 4 pixels, x=636..639; without: 8 pixels, x=636..643.
REQ-042 Assert reset during the 3rd pixel of (0,0)-(9,0) -> gfx_valid=0 the next cycle, no done, cmd_ready=1 after release.
